spi_reg_loader: RTL and testbench
=================================

// Module: spi_reg_loader
// PURPOSE
//  Upstream feeder for the signal generator's register write bus. Receives 8-bit
//  frames {addr[2:0],data[4:0]} over a 3-wire SPI-mode-0 link on uio pins.
//  Buffers them in a small FIFO and replays each as a slow, fully held write
//  transaction (wr_addr/wr_data/wr_strobe). A generator on the scaled clock
//  therefore samples every write exactly once.
// PARAMETERS
//  FIFO_DEPTH   4    words buffered; power of two, >=2
//  HOLD_CYCLES  128  clk cycles per drain phase (SETUP/STROBE/GAP); >= one scaled-clock period
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  spi_sclk    in   1  serial clock, async to clk, max clk/8
//  spi_cs_n    in   1  frame select, active low
//  spi_mosi    in   1  serial data, MSB first, sampled on sclk rising edge
//  ovf_clr     in   1  single-cycle pulse, clears overflow
//  wr_strobe   out  1  write strobe to signal generator
//  wr_addr     out  3  register address, stable SETUP..GAP
//  wr_data     out  5  register data, stable SETUP..GAP
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered
//  overflow    out  1  sticky: frame dropped because FIFO full
//  busy        out  1  FIFO non-empty or drain FSM not IDLE
// BEHAVIOUR
//  Reset (rst_n low, async): all outputs 0, FIFO empty, FSM IDLE, bit counter 0.
//  Input capture:
//  - spi_sclk, spi_cs_n, spi_mosi each pass a 2-FF synchronizer (cs_n resets to 1).
//  - Edges are detected on the synced signals.
//  - cs_n falling edge: bit counter <= 0.
//  - sclk rising edge while synced cs_n=0: shift in mosi, bit counter +1.
//  - 8th bit: frame complete; push request for one cycle; counter wraps to 0.
//  - Burst: further bits under the same cs_n low form further frames.
//  - cs_n rising with counter!=0: partial frame discarded, counter <= 0, no push.
//  - Latency: last sclk rise at pin -> fifo_level increments within 4 clk cycles.
//  FIFO:
//  - Push accepted if not full, or if a pop occurs in the same cycle.
//  - Otherwise the word is dropped and overflow <= 1.
//  - Simultaneous push+pop: level unchanged. Pointers wrap modulo FIFO_DEPTH.
//  - ovf_clr clears overflow. A drop in the same cycle as ovf_clr wins: overflow stays 1.
//  Drain FSM (phase counter width $clog2(HOLD_CYCLES+1)):
//  - IDLE: if FIFO non-empty, pop, load wr_addr/wr_data from head, counter <= 0 -> SETUP.
//    Strobe is 0 in IDLE. wr_addr/wr_data keep the last written values.
//  - SETUP: strobe 0; after HOLD_CYCLES cycles -> STROBE.
//  - STROBE: wr_strobe=1 (registered) for exactly HOLD_CYCLES cycles -> GAP.
//  - GAP: strobe 0, addr/data held, HOLD_CYCLES cycles -> IDLE.
//  - One write occupies 3*HOLD_CYCLES+1 cycles. Back-to-back writes have a 1-cycle IDLE gap.
//  - wr_addr/wr_data never change while wr_strobe=1 or during SETUP/GAP.
//  Reset mid-operation: strobe drops immediately (async). The buffered word and the
//  in-progress frame are lost.
//  No combinational path from any input to any output.
// STRUCTURE
//  Shared package sig_gen_pkg:
//  - ADDR_W=3, DATA_W=5, FRAME_W=8
//  - typedef struct packed {logic [2:0] addr; logic [4:0] data;} wr_word_t
//  - drain state enum {IDLE,SETUP,STROBE,GAP}
//  Sub-module sync_fifo (param WIDTH, DEPTH): push/pop/full/empty/level; async
//  active-low reset. Synchronizers, shift register and FSM live in spi_reg_loader.
// TESTING
//  1. Reset, one frame 8'b101_10011 at sclk=clk/8 -> fifo_level 1 within 4 clk.
//     Then SETUP(128), then wr_strobe high 128 cycles with wr_addr=5, wr_data=19.
//  2. Burst of 3 frames (0x21,0x42,0x63) under one cs_n low -> three writes in order.
//     Each is 385 cycles apart; busy drops after the third GAP.
//  3. Abort: cs_n rises after 5 bits, then full frame 0x7F -> only addr 3, data 31 written.
//  4. Overflow: 6 frames faster than drain, FIFO_DEPTH=4 -> frames 1-5 written
//     (1 popped early), frame 6 dropped, overflow=1; ovf_clr -> overflow=0.
//  5. Assert rst_n low during STROBE -> wr_strobe, fifo_level, busy all 0 same cycle.
//     Next frame after release is written normally.
//  6. Push coincident with pop at full -> push accepted, level stays 4, overflow stays 0.

Source files
------------

// File: rtl/sig_gen_pkg.sv
// Shared types for the signal-generator register write path.
package sig_gen_pkg;

  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 5;
  localparam int FRAME_W = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_word_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP
  } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == LVL_W'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_reg_loader.sv
// Collects {addr,data} frames from a mode-0 SPI link and replays each one as a
// slow, fully held register write so a generator on a scaled clock sees it once.
module spi_reg_loader
  import sig_gen_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          spi_sclk,
  input  logic                          spi_cs_n,
  input  logic                          spi_mosi,
  input  logic                          ovf_clr,
  output logic                          wr_strobe,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int BIT_W = $clog2(FRAME_W);

  logic [1:0]         r_sclk_s;
  logic [1:0]         r_cs_s;
  logic [1:0]         r_mosi_s;
  logic               r_sclk_d;
  logic               r_cs_d;
  logic [FRAME_W-2:0] r_shift;
  logic [BIT_W-1:0]   r_bit_cnt;

  drain_state_t       r_state;
  drain_state_t       w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_strobe;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic               r_ovf;

  logic               w_sclk_rise;
  logic               w_cs_fall;
  logic               w_cs_rise;
  logic               w_bit_en;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;
  wr_word_t           w_frame;
  wr_word_t           w_head;

  // Two-flop synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s <= 2'b00;
      r_cs_s   <= 2'b11;
      r_mosi_s <= 2'b00;
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sclk_s <= {r_sclk_s[0], spi_sclk};
      r_cs_s   <= {r_cs_s[0], spi_cs_n};
      r_mosi_s <= {r_mosi_s[0], spi_mosi};
      r_sclk_d <= r_sclk_s[1];
      r_cs_d   <= r_cs_s[1];
    end
  end

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_cs_fall   = ~r_cs_s[1] & r_cs_d;
  assign w_cs_rise   = r_cs_s[1] & ~r_cs_d;
  assign w_bit_en    = w_sclk_rise & ~r_cs_s[1];
  assign w_push      = w_bit_en && (r_bit_cnt == BIT_W'(FRAME_W - 1));
  assign w_frame     = {r_shift, r_mosi_s[1]};

  // Counter wraps after the 8th bit so a held-low cs_n yields back-to-back frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_cs_fall || w_cs_rise) begin
      r_bit_cnt <= '0;
    end else if (w_bit_en) begin
      r_shift   <= {r_shift[FRAME_W-3:0], r_mosi_s[1]};
      r_bit_cnt <= r_bit_cnt + BIT_W'(1);
    end
  end

  sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_frame),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  assign w_drop = w_push && w_full && !w_pop;

  // A drop beats a simultaneous clear so no lost frame goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_strobe <= (w_state_nxt == STROBE);
      if (w_pop) begin
        r_addr <= w_head.addr;
        r_data <= w_head.data;
      end
    end
  end

  // Each of SETUP/STROBE/GAP lasts HOLD_CYCLES; IDLE costs one cycle between writes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = SETUP;
        end
      end
      SETUP, STROBE, GAP: begin
        if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          w_cnt_nxt = '0;
          case (r_state)
            SETUP:   w_state_nxt = STROBE;
            STROBE:  w_state_nxt = GAP;
            default: w_state_nxt = IDLE;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign wr_strobe = r_strobe;
  assign wr_addr   = r_addr;
  assign wr_data   = r_data;
  assign overflow  = r_ovf;
  assign busy      = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_spi_reg_loader.sv
// Directed bench for spi_reg_loader: stimulus queues expected writes, a monitor checks each strobe.
module tb_spi_reg_loader;

  localparam int H = 128;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       ovf_clr  = 1'b0;
  logic       wr_strobe;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int lvl_peak;
  int lvl_cyc;
  int t_ref;
  logic [7:0] sb_q[$];
  int         rise_q[$];

  spi_reg_loader #(
    .FIFO_DEPTH  (4),
    .HOLD_CYCLES (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .ovf_clr    (ovf_clr),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each strobe rise, checks pulse length and hold.
  logic       prev_stb = 1'b0;
  int         hi_cnt   = 0;
  logic [7:0] hold_w;
  logic       stable;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb = 1'b0;
      hi_cnt   = 0;
    end else begin
      if (wr_strobe && !prev_stb) begin
        rise_q.push_back(cyc);
        check("write_expected", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) check("wr_word", 32'({wr_addr, wr_data}), 32'(sb_q.pop_front()));
        hold_w = {wr_addr, wr_data};
        stable = 1'b1;
        hi_cnt = 1;
      end else if (wr_strobe) begin
        hi_cnt++;
        if ({wr_addr, wr_data} !== hold_w) stable = 1'b0;
      end else if (prev_stb) begin
        check("strobe_len", hi_cnt, H);
        check("word_held", int'(stable && ({wr_addr, wr_data} === hold_w)), 1);
      end
      prev_stb = wr_strobe;
    end
  end

  task automatic sclk_high();
    spi_sclk = 1'b1;
    lvl_peak = 0;
    repeat (4) begin
      @(negedge clk);
      if (int'(fifo_level) > lvl_peak) begin
        lvl_peak = int'(fifo_level);
        lvl_cyc  = cyc;
      end
    end
    spi_sclk = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    spi_mosi = b;
    repeat (4) @(negedge clk);
    sclk_high();
  endtask

  task automatic send_frame(input logic [7:0] f, input logic expect_write);
    for (int i = 7; i >= 0; i--) send_bit(f[i]);
    if (expect_write) sb_q.push_back(f);
  endtask

  task automatic set_cs(input logic v);
    spi_cs_n = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("busy_drops", 32'(busy), 0);
  endtask

  task automatic wait_stb(input logic v, input int budget);
    int n = 0;
    while (wr_strobe !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("strobe_wait", 32'(wr_strobe), 32'(v));
  endtask

  task automatic wait_level(input int v, input int budget);
    int n = 0;
    while (int'(fifo_level) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("level_wait", 32'(fifo_level), v);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_strobe", 32'(wr_strobe), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_word", 32'({wr_addr, wr_data}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single frame, latency and SETUP length
    rise_q = {};
    set_cs(1'b0);
    send_frame(8'b101_10011, 1'b1);
    check("t1_level_pulse", lvl_peak, 1);
    t_ref = lvl_cyc;
    set_cs(1'b1);
    wait_idle(1000);
    check("t1_writes", rise_q.size(), 1);
    if (rise_q.size() == 1) check("t1_setup_len", rise_q[0] - t_ref, H + 1);

    // 2: burst of three frames under one cs_n low
    rise_q = {};
    set_cs(1'b0);
    send_frame(8'h21, 1'b1);
    send_frame(8'h42, 1'b1);
    send_frame(8'h63, 1'b1);
    set_cs(1'b1);
    wait_idle(2000);
    check("t2_writes", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      check("t2_spacing_a", rise_q[1] - rise_q[0], 3 * H + 1);
      check("t2_spacing_b", rise_q[2] - rise_q[1], 3 * H + 1);
      check("t2_busy_drop", cyc - rise_q[2], 2 * H);
    end

    // 3: partial frame discarded when cs_n rises early
    rise_q = {};
    set_cs(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    set_cs(1'b1);
    set_cs(1'b0);
    send_frame(8'h7F, 1'b1);
    set_cs(1'b1);
    wait_idle(1000);
    check("t3_writes", rise_q.size(), 1);

    // 4: overflow with six fast frames, then clear
    rise_q = {};
    set_cs(1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h32, 1'b1);
    send_frame(8'h53, 1'b1);
    send_frame(8'h74, 1'b1);
    send_frame(8'h95, 1'b1);
    send_frame(8'hB6, 1'b0);
    check("t4_level_full", 32'(fifo_level), 4);
    check("t4_ovf_set", 32'(overflow), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 0);

    // 6: refill to full, then land a push on the same edge as the next pop
    wait_level(3, 300);
    send_frame(8'hD7, 1'b1);
    check("t6_level_refull", 32'(fifo_level), 4);
    g = 8'hF8;
    for (int i = 7; i >= 1; i--) send_bit(g[i]);
    spi_mosi = g[0];
    wait_stb(1'b1, 400);
    wait_stb(1'b0, 400);
    repeat (H - 2) @(negedge clk);
    spi_sclk = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_level_at_pop", 32'(fifo_level), 4);
    @(negedge clk);
    check("t6_level_after", 32'(fifo_level), 4);
    check("t6_ovf_clear", 32'(overflow), 0);
    spi_sclk = 1'b0;
    sb_q.push_back(g);
    set_cs(1'b1);
    wait_idle(4000);
    check("t46_writes", rise_q.size(), 7);

    // 5: reset during STROBE
    set_cs(1'b0);
    send_frame(8'h2A, 1'b1);
    send_frame(8'h4C, 1'b1);
    set_cs(1'b1);
    wait_stb(1'b1, 400);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_strobe", 32'(wr_strobe), 0);
    check("t5_level", 32'(fifo_level), 0);
    check("t5_busy", 32'(busy), 0);
    sb_q = {};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rise_q = {};
    set_cs(1'b0);
    send_frame(8'h6E, 1'b1);
    set_cs(1'b1);
    wait_idle(1000);
    check("t5_writes", rise_q.size(), 1);

    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
